// File: rtl/piradip_axil_pkg.sv
// piradip_axil_pkg: shared AXI-Lite response codes, register-file FSM states
// and the byte-strobe merge used on register writes.
package piradip_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = strb[k] ? new_val[k*8 +: 8] : old_val[k*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/piradip_axil_regfile.sv
// piradip_axil_regfile: AXI4-Lite slave exposing NREGS 32-bit read/write registers,
// with independent single-outstanding write and read channels.
module piradip_axil_regfile
    import piradip_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NREGS = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [2:0]              arprot,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [NREGS*DATA_WIDTH-1:0] regs_out,
    output logic [NREGS-1:0]        wr_pulse
);

    localparam int IW = ADDR_WIDTH - 2;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic ready_en;
    logic [IW-1:0] aw_idx_q, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wdata_q, wr_data, rd_val;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wr_strb;
    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic aw_hs, w_hs, ar_hs, wr_commit, wr_ok;
    logic unused_ok;

    assign unused_ok = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};
    assign aw_hs = awvalid && awready;
    assign w_hs = wvalid && wready;
    assign ar_hs = arvalid && arready;
    // The completing handshake's payload is used directly; the earlier one comes from the latch.
    assign wr_idx = aw_hs ? awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
    assign wr_data = w_hs ? wdata : wdata_q;
    assign wr_strb = w_hs ? wstrb : wstrb_q;
    assign wr_ok = 32'(wr_idx) < NREGS;
    assign rd_idx = araddr[ADDR_WIDTH-1:2];
    assign wr_commit = (w_next == W_RESP) && (w_state != W_RESP);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            ready_en <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:      w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : W_IDLE;
            W_HAVE_ADDR: w_next = w_hs ? W_RESP : W_HAVE_ADDR;
            W_HAVE_DATA: w_next = aw_hs ? W_RESP : W_HAVE_DATA;
            default:     w_next = bready ? W_IDLE : W_RESP;
        endcase
        r_next = ar_hs ? R_DATA : (r_state == R_DATA && rready) ? R_IDLE : r_state;
    end

    // Readies depend only on registered state, held low until the first edge after reset.
    always_comb begin
        awready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_DATA);
        wready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
        bvalid = w_state == W_RESP;
        arready = ready_en && r_state == R_IDLE;
        rvalid = r_state == R_DATA;
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NREGS; i++) if (32'(rd_idx) == i) rd_val = regs[i];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_idx_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp <= RESP_OKAY;
            rresp <= RESP_OKAY;
            rdata <= '0;
            wr_pulse <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
        end else begin
            if (aw_hs) aw_idx_q <= awaddr[ADDR_WIDTH-1:2];
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            wr_pulse <= '0;
            if (wr_commit) begin
                bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NREGS; i++) begin
                    if (32'(wr_idx) == i) begin
                        regs[i] <= strb_merge(regs[i], wr_data, wr_strb);
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
            if (ar_hs) begin
                rdata <= rd_val;
                rresp <= (32'(rd_idx) < NREGS) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_out
        assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end

endmodule
